// File: rtl/key_event_ctrl.sv
// Front-panel key controller: sync/debounce N keys, classify SHORT/LONG/REPEAT,
// and serialise one pending event per key onto a valid/ready stream.
module key_event_ctrl #(
  parameter int N_KEYS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = 270000,
  parameter int LONG_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [KW-1:0]     ev_key,
  output logic [1:0]        ev_type,
  output logic [N_KEYS-1:0] key_level,
  output logic              overflow
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  typedef enum logic [1:0] {IDLE, HELD, RPT} key_state_t;

  logic [N_KEYS-1:0] sync1, sync2, pressed;
  logic [DW-1:0]     deb_cnt [N_KEYS];

  key_state_t        state     [N_KEYS];
  key_state_t        state_nxt [N_KEYS];
  logic [HW-1:0]     hold_cnt  [N_KEYS];
  logic [HW-1:0]     hold_nxt  [N_KEYS];
  logic [N_KEYS-1:0] post;
  logic [1:0]        post_type [N_KEYS];

  logic [N_KEYS-1:0] pend;
  logic [1:0]        ptype [N_KEYS];
  logic [KW-1:0]     ptr;
  logic              load, grant;
  logic [KW-1:0]     grant_idx;
  logic [KW-1:0]     slot_idx;
  int unsigned       slot;

  // Synchronisers come out of reset holding the released pad level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= {N_KEYS{ACTIVE_LOW}};
      sync2 <= {N_KEYS{ACTIVE_LOW}};
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ {N_KEYS{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_level <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (pressed[i] == key_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]   <= '0;
          key_level[i] <= ~key_level[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]    <= IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i]    <= state_nxt[i];
        hold_cnt[i] <= hold_nxt[i];
      end
    end
  end

  // Release wins over a coinciding LONG/REPEAT terminal count.
  always_comb begin
    post = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      state_nxt[i] = state[i];
      hold_nxt[i]  = hold_cnt[i];
      post_type[i] = EV_NONE;
      case (state[i])
        IDLE: begin
          if (key_level[i]) begin
            state_nxt[i] = HELD;
            hold_nxt[i]  = '0;
          end
        end
        HELD: begin
          if (!key_level[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EV_SHORT;
            state_nxt[i] = IDLE;
          end else if (hold_cnt[i] == LONG_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = EV_LONG;
            hold_nxt[i]  = '0;
            state_nxt[i] = RPT;
          end else begin
            hold_nxt[i] = hold_cnt[i] + 1'b1;
          end
        end
        RPT: begin
          if (!key_level[i]) begin
            state_nxt[i] = IDLE;
          end else if (hold_cnt[i] == RPT_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = EV_REPEAT;
            hold_nxt[i]  = '0;
          end else begin
            hold_nxt[i] = hold_cnt[i] + 1'b1;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Round-robin search starting at ptr, wrapping at N_KEYS.
  always_comb begin
    load      = !ev_valid || ev_ready;
    grant     = 1'b0;
    grant_idx = '0;
    slot      = '0;
    slot_idx  = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      slot = 32'(ptr) + i;
      if (slot >= N_KEYS) slot = slot - N_KEYS;
      slot_idx = KW'(slot);
      if (load && !grant && pend[slot_idx]) begin
        grant     = 1'b1;
        grant_idx = slot_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ev_valid <= 1'b0;
      ev_key   <= '0;
      ev_type  <= EV_NONE;
      ptr      <= '0;
      overflow <= 1'b0;
      pend     <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) ptype[i] <= EV_NONE;
    end else begin
      if (load) begin
        ev_valid <= grant;
        if (grant) begin
          ev_key  <= grant_idx;
          ev_type <= ptype[grant_idx];
          ptr     <= (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      // A grant reads the old type, so a same-cycle post simply stays pending.
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (post[i]) begin
          pend[i]  <= 1'b1;
          ptype[i] <= post_type[i];
          if (pend[i] && !(grant && grant_idx == KW'(i))) overflow <= 1'b1;
        end else if (grant && grant_idx == KW'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule
